// File: rtl/dds_pkg.sv
// dds_pkg: shared voice-scheduler constants and FSM state encoding
package dds_pkg;
   localparam int NUM_VOICES = 4;
   localparam int SEL_W = 2;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/voice_scheduler_mix_accum.sv
// mix_accum: signed clear/add/hold accumulator, two guard bits above the sample width
module mix_accum #(
   parameter int W_IN = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_i,
   input  logic                   add_i,
   input  logic signed [W_IN-1:0] din_i,
   output logic signed [W_IN+1:0] nxt_o
);
   logic signed [W_IN+1:0] acc_q;
   logic signed [W_IN+1:0] ext;
   assign ext = {{2{din_i[W_IN-1]}}, din_i};
   // next value: clear wins, otherwise add the sample or hold
   always_comb nxt_o = clr_i ? '0 : acc_q + (add_i ? ext : '0);
   // accumulator register
   always_ff @(posedge clk or posedge rst)
      if (rst) acc_q <= '0;
      else acc_q <= nxt_o;
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: time-multiplexes four voices through one wave LUT and mixes them per sample tick
module voice_scheduler
   import dds_pkg::*;
#(
   parameter int M = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_tick,
   input  logic [NUM_VOICES-1:0] voice_en,
   input  logic                  clr_overrun,
   input  logic signed [M-1:0]   wave_in,
   output logic [SEL_W-1:0]      sel,
   output logic                  lut_req,
   output logic signed [M+1:0]   mix_out,
   output logic                  mix_valid,
   output logic                  busy,
   output logic                  overrun
);
   state_t                state_q;
   logic [SEL_W-1:0]      slot_q;
   logic [NUM_VOICES-1:0] en_q;
   logic                  prev_req_q;
   logic                  overrun_q;
   logic                  mix_valid_q;
   logic signed [M+1:0]   mix_out_q;
   logic signed [M+1:0]   acc_nxt;
   logic                  start;
   assign start     = sample_tick && state_q == IDLE;
   assign sel       = state_q == ISSUE ? slot_q : '0;
   assign lut_req   = state_q == ISSUE && en_q[slot_q];
   assign busy      = state_q != IDLE;
   assign overrun   = overrun_q;
   assign mix_out   = mix_out_q;
   assign mix_valid = mix_valid_q;
   // wave_in lags sel by one cycle, so the previous slot's request gates the add
   mix_accum #(.W_IN(M)) u_accum (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start),
      .add_i (prev_req_q),
      .din_i (wave_in),
      .nxt_o (acc_nxt)
   );
   // frame sequencer, enable latch, overrun flag and registered mix result
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         en_q        <= '0;
         prev_req_q  <= 1'b0;
         overrun_q   <= 1'b0;
         mix_valid_q <= 1'b0;
         mix_out_q   <= '0;
      end else begin
         prev_req_q  <= lut_req;
         mix_valid_q <= state_q == DRAIN;
         overrun_q   <= (sample_tick && state_q != IDLE) || (overrun_q && !clr_overrun);
         if (state_q == DRAIN) mix_out_q <= acc_nxt;
         case (state_q)
            IDLE:
               if (sample_tick) begin
                  en_q    <= voice_en;
                  slot_q  <= '0;
                  state_q <= ISSUE;
               end
            ISSUE: begin
               slot_q <= slot_q + 1'b1;
               if (slot_q == SEL_W'(NUM_VOICES - 1)) state_q <= DRAIN;
            end
            DRAIN:   state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter: M, default 12, width of the shared wave sample in bits (two's-complement signed).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: sample_tick  input  1  one-cycle pulse at the output sample rate; starts one mixing frame.
REQ-005 Port: voice_en  input  4  per-voice enable, bit k = voice k.
REQ-006 Port: clr_overrun  input  1  one-cycle pulse; clears the overrun flag.
REQ-007 Port: wave_in  input  M  shared wave-LUT output; valid exactly one cycle after the matching sel.
REQ-008 Port: sel  output  2  select for the shared 4-input voice mux feeding the LUT.
REQ-009 Port: lut_req  output  1  high when the current slot's voice is enabled.
REQ-010 Port: mix_out  output  M+2  signed sum of the enabled voices for the last completed frame.
REQ-011 Port: mix_valid  output  1  one-cycle pulse when mix_out updates.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.
REQ-013 Port: overrun  output  1  sticky flag; a tick arrived while busy.

Function
REQ-014 The FSM shall have states IDLE, ISSUE, DRAIN and DONE.
REQ-015 In IDLE, a sample_tick in cycle T shall latch voice_en, clear the accumulator and enter ISSUE in cycle T+1 with slot=0.
REQ-016 In ISSUE, sel shall equal slot, and lut_req shall equal the latched enable bit for that slot.
REQ-017 The slot counter shall advance 0,1,2,3 over cycles T+1..T+4; after slot 3 the FSM shall enter DRAIN (cycle T+5).
REQ-018 In each cycle T+2..T+5, the accumulator shall add sign-extended wave_in if the enable bit of the previous slot was set, and add 0 otherwise.
REQ-019 DRAIN shall last exactly one cycle; in DONE (cycle T+6), mix_out shall take the final accumulator value and mix_valid shall be 1. The FSM shall return to IDLE at T+7.
REQ-020 Frame latency, tick to mix_valid, shall be fixed at 6 cycles regardless of voice_en.
REQ-021 All four slots shall always be visited; disabled voices keep sel sequencing, with lut_req=0 and a zero contribution.
REQ-022 Accumulation shall be signed, M+2 bits wide, without saturation. Four full-scale samples shall not overflow.
REQ-023 Outside ISSUE, sel shall be 0 and lut_req shall be 0.
REQ-024 mix_out shall hold its value between DONE cycles.
REQ-025 A sample_tick in any state other than IDLE, including DONE, shall be ignored and shall set overrun.
REQ-026 clr_overrun shall clear overrun. When a set and a clear occur in the same cycle, the set shall win.
REQ-027 Changes to voice_en during a frame shall not affect that frame.
REQ-028 busy shall be 1 in ISSUE, DRAIN and DONE.

Reset
REQ-029 Asserting rst at any time, including mid-frame, shall immediately force: state=IDLE, slot=0, sel=0, lut_req=0, mix_out=0, mix_valid=0, busy=0, overrun=0, accumulator=0 and latched enables=0.
REQ-030 After rst deasserts, the first frame shall start only on a new sample_tick.

Structure
REQ-031 A shared package dds_pkg shall hold the FSM state encoding, NUM_VOICES=4 and SEL_W=2.
REQ-032 A single sub-module, mix_accum, shall hold the clear/add/hold signed accumulator; all other logic shall stay in voice_scheduler.

Verification (M=12)
REQ-033 voice_en=4'b1111, wave_in=100 for every slot, one tick -> sel 0,1,2,3 over T+1..T+4; mix_out=400 with mix_valid at T+6.
REQ-034 voice_en=4'b0101, wave_in=slot-indexed {10,20,30,40} -> lut_req pattern 1,0,1,0; mix_out=40.
REQ-035 voice_en=4'b1111, wave_in=-2048 for all slots -> mix_out=-8192 with no overflow; then wave_in=2047 for all slots -> mix_out=8188.
REQ-036 Second tick at T+3 -> ignored, overrun=1, frame completes at T+6; clr_overrun and a tick in the same cycle while busy -> overrun stays 1.
REQ-037 rst asserted at T+3 -> all outputs 0 asynchronously, busy=0; a new tick then yields a correct frame.
REQ-038 voice_en changed from 4'b1111 to 4'b0000 at T+2 -> mix_out still sums all four voices.
